// File: rtl/gpio_port_if.sv
// ============================================================================
//  Module   : gpio_port_if
//  Purpose  : CSR bus bundle between the CSR decoder (master) and a
//             peripheral register block (slave): 5-bit address, 8-bit write
//             data, write strobe and registered 8-bit read data.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface gpio_port_if;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (output csr_a, output csr_di, output csr_we, input  csr_do);
  modport slave  (input  csr_a, input  csr_di, input  csr_we, output csr_do);
endinterface

`default_nettype wire

// File: rtl/gpio_port.sv
// ============================================================================
//  Module   : gpio_port
//  Purpose  : 8-bit GPIO block on the CSR bus. Per-pin output data and
//             output enable, synchronised pin readback, and (optionally)
//             per-pin any-edge interrupts with enable mask and W1C pending
//             bits folded into one registered level irq.
//  Options  : GPIO_IRQ_EN - when defined, builds IER/IPR, edge detection and
//             irq; when undefined, 0x3/0x4 read zero and irq is tied low.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_port #(
  parameter logic [7:0] INIT_OUT = 8'h00,
  parameter logic [7:0] INIT_OE  = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  gpio_port_if.slave  bus,
  input  logic [7:0]  in,
  output logic [7:0]  out,
  output logic [7:0]  oe,
  output logic        irq
);

  localparam logic [4:0] c_ADDR_DIR = 5'h00;
  localparam logic [4:0] c_ADDR_OUT = 5'h01;
  localparam logic [4:0] c_ADDR_IN  = 5'h02;
`ifdef GPIO_IRQ_EN
  localparam logic [4:0] c_ADDR_IER = 5'h03;
  localparam logic [4:0] c_ADDR_IPR = 5'h04;
`endif

  logic [7:0] r_dir;
  logic [7:0] r_out;
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] r_do;
  logic [7:0] w_rd_data;
  logic [7:0] w_ier_rd;
  logic [7:0] w_ipr_rd;

  // Direction and output-data registers, written straight from the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir <= INIT_OE;
      r_out <= INIT_OUT;
    end else if (bus.csr_we) begin
      if (bus.csr_a == c_ADDR_DIR) r_dir <= bus.csr_di;
      if (bus.csr_a == c_ADDR_OUT) r_out <= bus.csr_di;
    end
  end

  // Two-flop synchroniser for the asynchronous pin levels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [7:0] r_prev;
  logic [7:0] r_ier;
  logic [7:0] r_ipr;
  logic       r_irq;
  logic [7:0] w_edge;
  logic [7:0] w_clr;

  // Any change between consecutive synchronised samples is an edge
  assign w_edge = r_sync2 ^ r_prev;
  assign w_clr  = (bus.csr_we && (bus.csr_a == c_ADDR_IPR)) ? bus.csr_di : 8'h00;

  // Edge history, enable mask and pending bits; a new edge beats a W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 8'h00;
      r_ier  <= 8'h00;
      r_ipr  <= 8'h00;
    end else begin
      r_prev <= r_sync2;
      if (bus.csr_we && (bus.csr_a == c_ADDR_IER)) r_ier <= bus.csr_di;
      r_ipr <= (r_ipr & ~w_clr) | w_edge;
    end
  end

  // Registered interrupt level from enabled pending bits
  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= |(r_ipr & r_ier);
  end

  assign w_ier_rd = r_ier;
  assign w_ipr_rd = r_ipr;
  assign irq      = r_irq;
`else
  assign w_ier_rd = 8'h00;
  assign w_ipr_rd = 8'h00;
  assign irq      = 1'b0;
`endif

  // Read-data multiplexer over the current register contents
  always_comb begin
    w_rd_data = 8'h00;
    case (bus.csr_a)
      c_ADDR_DIR: w_rd_data = r_dir;
      c_ADDR_OUT: w_rd_data = r_out;
      c_ADDR_IN:  w_rd_data = r_sync2;
      5'h03:      w_rd_data = w_ier_rd;
      5'h04:      w_rd_data = w_ipr_rd;
      default:    w_rd_data = 8'h00;
    endcase
  end

  // Read data is registered every cycle regardless of the write strobe
  always_ff @(posedge clk) begin
    if (rst) r_do <= 8'h00;
    else     r_do <= w_rd_data;
  end

  assign bus.csr_do = r_do;
  assign out        = r_out;
  assign oe         = r_dir;

endmodule

`default_nettype wire

// File: tb/tb_gpio_port.sv
// ============================================================================
//  Module   : tb_gpio_port
//  Purpose  : Self-checking bench for gpio_port. Each driven cycle pushes the
//             expected post-edge outputs into a queue; a monitor pops one
//             entry per cycle and compares csr_do, out, oe and irq.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gpio_port;

  typedef struct packed {
    logic [7:0] rdata;
    logic [7:0] out;
    logic [7:0] oe;
    logic       irq;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pin;
  logic [7:0] out;
  logic [7:0] oe;
  logic       irq;

  gpio_port_if bus ();

  gpio_port dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .in  (pin),
    .out (out),
    .oe  (oe),
    .irq (irq)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;

  // Reference state: register contents plus the pin levels sampled at the
  // last three edges (oldest first); the IN register shows the level from
  // two edges back, the edge detector compares it with the one before it.
  logic [7:0] m_dir, m_out, m_ier, m_ipr, m_do;
  logic       m_irq;
  logic [7:0] hist[$];

  task automatic cyc(input logic r, input logic [4:0] a, input logic w,
                     input logic [7:0] d, input logic [7:0] p);
    logic [7:0] seen, older, rd, chg, clr;
    logic       nirq;
    exp_t       e;
    rst        = r;
    bus.csr_a  = a;
    bus.csr_we = w;
    bus.csr_di = d;
    pin        = p;
    if (r) begin
      m_dir = 8'h00; m_out = 8'h00; m_ier = 8'h00; m_ipr = 8'h00;
      m_do  = 8'h00; m_irq = 1'b0;
      hist  = '{8'h00, 8'h00, 8'h00};
    end else begin
      seen  = hist[1];
      older = hist[0];
      case (a)
        5'd0:    rd = m_dir;
        5'd1:    rd = m_out;
        5'd2:    rd = seen;
        5'd3:    rd = m_ier;
        5'd4:    rd = m_ipr;
        default: rd = 8'h00;
      endcase
      nirq = (m_ipr & m_ier) != 8'h00;
      chg  = seen ^ older;
      clr  = (w && a == 5'd4) ? d : 8'h00;
      if (w && a == 5'd0) m_dir = d;
      if (w && a == 5'd1) m_out = d;
`ifdef GPIO_IRQ_EN
      if (w && a == 5'd3) m_ier = d;
      m_ipr = (m_ipr & ~clr) | chg;
      m_irq = nirq;
`else
      m_ier = 8'h00;
      m_ipr = 8'h00;
      m_irq = 1'b0;
`endif
      m_do = rd;
      hist.push_back(p);
      void'(hist.pop_front());
    end
    e.rdata = m_do;
    e.out   = m_out;
    e.oe    = m_dir;
    e.irq   = m_irq;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one set of DUT outputs per clock, sampled mid-cycle
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("csr_do", bus.csr_do, e.rdata);
        chk("out",    out,        e.out);
        chk("oe",     oe,         e.oe);
        chk("irq",    {7'd0, irq}, {7'd0, e.irq});
      end
    end
  end

  initial begin
    logic [7:0] cur;
    cur = 8'h00;
    // reset and reset-value readback
    for (int i = 0; i < 3; i++) cyc(1'b1, 5'd0, 1'b0, 8'h00, 8'h00);
    cyc(0, 5'd0, 0, 8'h00, 8'h00);
    cyc(0, 5'd1, 0, 8'h00, 8'h00);
    cyc(0, 5'd3, 0, 8'h00, 8'h00);
    cyc(0, 5'd4, 0, 8'h00, 8'h00);
    cyc(0, 5'd4, 0, 8'h00, 8'h00);
    // output data and direction
    cyc(0, 5'd1, 1, 8'haa, 8'h00);
    cyc(0, 5'd0, 1, 8'h0f, 8'h00);
    cyc(0, 5'd1, 0, 8'h00, 8'h00);
    cyc(0, 5'd0, 0, 8'h00, 8'h00);
    cyc(0, 5'd0, 0, 8'h00, 8'h00);
    // edge interrupts
    cyc(0, 5'd3, 1, 8'h10, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 5'd4, 0, 8'h00, 8'h20);
    for (int i = 0; i < 5; i++) cyc(0, 5'd4, 0, 8'h00, 8'h30);
    for (int i = 0; i < 5; i++) cyc(0, 5'd2, 0, 8'h00, 8'h00);
    cyc(0, 5'd4, 0, 8'h00, 8'h00);
    cyc(0, 5'd4, 1, 8'h10, 8'h00);
    cyc(0, 5'd4, 0, 8'h00, 8'h00);
    cyc(0, 5'd4, 0, 8'h00, 8'h00);
    cyc(0, 5'd4, 1, 8'h20, 8'h00);
    cyc(0, 5'd4, 0, 8'h00, 8'h00);
    cyc(0, 5'd4, 0, 8'h00, 8'h00);
    // bit4 edge landing in the same cycle as its W1C
    cyc(0, 5'd4, 0, 8'h00, 8'h10);
    cyc(0, 5'd4, 0, 8'h00, 8'h10);
    cyc(0, 5'd4, 1, 8'h10, 8'h10);
    for (int i = 0; i < 3; i++) cyc(0, 5'd4, 0, 8'h00, 8'h10);
    // pin readback, unmapped address, write to read-only IN
    for (int i = 0; i < 5; i++) cyc(0, 5'd2, 0, 8'h00, 8'h5a);
    cyc(0, 5'd7, 0, 8'h00, 8'h5a);
    cyc(0, 5'd7, 0, 8'h00, 8'h5a);
    cyc(0, 5'd2, 1, 8'hff, 8'h5a);
    cyc(0, 5'd0, 0, 8'h00, 8'h5a);
    cyc(0, 5'd1, 0, 8'h00, 8'h5a);
    cyc(0, 5'd2, 0, 8'h00, 8'h5a);
    cyc(0, 5'd3, 0, 8'h00, 8'h5a);
    // mid-operation reset
    cyc(1, 5'd0, 0, 8'h00, 8'h5a);
    cyc(0, 5'd1, 0, 8'h00, 8'h5a);
    cyc(0, 5'd4, 0, 8'h00, 8'h5a);
    // randomized traffic
    cur = 8'h5a;
    for (int i = 0; i < 600; i++) begin
      logic [4:0] a;
      logic       w, r;
      if ($urandom_range(0, 3) == 0) cur = cur ^ 8'($urandom_range(1, 255));
      a = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(5, 31)) : 5'($urandom_range(0, 4));
      w = $urandom_range(0, 2) == 0;
      r = $urandom_range(0, 99) == 0;
      cyc(r, a, w, 8'($urandom), cur);
    end
    cyc(0, 5'd0, 0, 8'h00, cur);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
